// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: single-address I2C target with a write strobe and a clock-stretched read handshake
module i2c_slave_responder #(
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDRESS = 7'h22,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic start_o,
  output logic stop_o,
  output logic op_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  output logic wr_valid_o,
  output logic rd_req_o,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
  input  logic rd_valid_i,
  output logic busy_o
);
  localparam int W = I2C_DATA_WIDTH;
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_WAIT, RD_BYTE, RD_ACK, SKIP} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_q, sda_q, scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] cnt;
  logic [W-1:0] sh;
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start_det = scl_s & sda_q & ~sda_s;
  assign stop_det = scl_s & ~sda_q & sda_s;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  // the bit counter wraps to 0 after every byte, so only START has to clear it
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      scl_o <= 1'b1;
      sda_o <= 1'b1;
      start_o <= 1'b0;
      stop_o <= 1'b0;
      op_o <= 1'b0;
      wr_data_o <= '0;
      wr_valid_o <= 1'b0;
      rd_req_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      start_o <= 1'b0;
      stop_o <= 1'b0;
      wr_valid_o <= 1'b0;
      if (stop_det) begin
        state <= IDLE;
        sda_o <= 1'b1;
        scl_o <= 1'b1;
        rd_req_o <= 1'b0;
        busy_o <= 1'b0;
        stop_o <= 1'b1;
      end else if (start_det) begin
        state <= ADDR;
        cnt <= '0;
        sda_o <= 1'b1;
        scl_o <= 1'b1;
        rd_req_o <= 1'b0;
        start_o <= 1'b1;
      end else
        case (state)
          ADDR: if (scl_rise) begin
            sh <= {sh[W-2:0], sda_s};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (sh[W-2:0] == SLAVE_ADDRESS) begin
                op_o <= sda_s;
                busy_o <= 1'b1;
                state <= ADDR_ACK;
              end else
                state <= SKIP;
            end
          end
          // sda_o doubles as the ACK phase: first fall pulls low, second fall releases
          ADDR_ACK, WR_ACK: if (scl_fall) begin
            sda_o <= ~sda_o;
            if (!sda_o) begin
              state <= op_o ? RD_WAIT : WR_BYTE;
              rd_req_o <= op_o;
              scl_o <= ~op_o;
            end
          end
          WR_BYTE: if (scl_rise) begin
            sh <= {sh[W-2:0], sda_s};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              wr_data_o <= {sh[W-2:0], sda_s};
              wr_valid_o <= 1'b1;
              state <= WR_ACK;
            end
          end
          RD_WAIT: if (rd_valid_i) begin
            sh <= rd_data_i;
            sda_o <= rd_data_i[W-1];
            rd_req_o <= 1'b0;
            scl_o <= 1'b1;
            state <= RD_BYTE;
          end
          RD_BYTE: if (scl_fall) begin
            sh <= sh << 1;
            sda_o <= (cnt == 3'd7) | sh[W-2];
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) state <= RD_ACK;
          end
          RD_ACK: if (scl_rise && sda_s) state <= SKIP;
            else if (scl_fall) begin
              state <= RD_WAIT;
              rd_req_o <= 1'b1;
              scl_o <= 1'b0;
            end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: bit-banged I2C master against the responder, with write/read scoreboards
module tb_i2c_slave_responder;
  localparam int T = 6;
  typedef struct {
    logic [7:0] addr;
    int n, base, delay, exp_acks, exp_wr, exp_rdreq, st_lo, st_hi;
    logic busy, op;
  } vec_t;
  logic clk = 0, rst = 1, m_scl = 1, m_sda = 1;
  logic scl_o, sda_o, start_o, stop_o, op_o, wr_valid_o, rd_req_o, busy_o;
  logic rd_valid = 0, req_q = 0;
  logic [7:0] wr_data_o, rd_data = 0;
  logic scl_bus, sda_bus;
  logic [7:0] wr_exp[$], rd_src[$], rd_exp[$];
  int checks = 0, errors = 0, rd_delay = 0;
  int n_start = 0, n_stop = 0, n_wr = 0, n_rdreq = 0, n_scl_low = 0, n_sda_low = 0, n_busy = 0;
  vec_t vecs[4];
  assign scl_bus = m_scl & scl_o;
  assign sda_bus = m_sda & sda_o;
  always #5 clk = ~clk;
  i2c_slave_responder dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl_bus), .sda_i(sda_bus), .scl_o(scl_o), .sda_o(sda_o),
    .start_o(start_o), .stop_o(stop_o), .op_o(op_o), .wr_data_o(wr_data_o), .wr_valid_o(wr_valid_o),
    .rd_req_o(rd_req_o), .rd_data_i(rd_data), .rd_valid_i(rd_valid), .busy_o(busy_o)
  );
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask
  always @(negedge clk) begin
    if (start_o) n_start++;
    if (stop_o) n_stop++;
    if (rd_req_o && !req_q) n_rdreq++;
    req_q = rd_req_o;
    if (!scl_o) n_scl_low++;
    if (!sda_o) n_sda_low++;
    if (busy_o) n_busy++;
    if (wr_valid_o) begin
      n_wr++;
      check("wr_rdreq_exclusive", rd_req_o, 0);
      check("wr_queue_depth", wr_exp.size(), 1);
      if (wr_exp.size() != 0) check("wr_data", wr_data_o, wr_exp.pop_front());
    end
  end
  initial begin
    int w = 0;
    forever begin
      @(negedge clk);
      if (rd_valid) rd_valid = 0;
      else if (rd_req_o) begin
        if (w < rd_delay) w++;
        else begin
          w = 0;
          rd_data = rd_src.size() != 0 ? rd_src.pop_front() : 8'hEE;
          rd_exp.push_back(rd_data);
          rd_valid = 1;
        end
      end
    end
  end
  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic scl_high();
    int k = 0;
    m_scl = 1;
    while (!scl_bus && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (!scl_bus) check("scl_release_timeout", scl_bus, 1);
  endtask
  task automatic bit_x(input logic b, output logic r);
    m_sda = b;
    wt(T);
    scl_high();
    wt(T);
    r = sda_bus;
    m_scl = 0;
    wt(T);
  endtask
  task automatic start_c();
    m_sda = 1;
    wt(T);
    scl_high();
    wt(T);
    m_sda = 0;
    wt(T);
    m_scl = 0;
    wt(T);
  endtask
  task automatic stop_c();
    m_sda = 0;
    wt(T);
    scl_high();
    wt(T);
    m_sda = 1;
    wt(T);
  endtask
  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(d[i], r);
    bit_x(1'b1, r);
    ack = ~r;
  endtask
  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      d[i] = r;
    end
    bit_x(nack, r);
  endtask
  task automatic run_vec(input vec_t v);
    int s_start = n_start, s_stop = n_stop, s_wr = n_wr, s_req = n_rdreq;
    int s_scl = n_scl_low, s_sda = n_sda_low, s_busy = n_busy, acks = 0;
    logic a;
    logic [7:0] d;
    rd_delay = v.delay;
    if (v.addr[0]) for (int i = 0; i < v.n; i++) rd_src.push_back(8'(v.base + i));
    start_c();
    wr_byte(v.addr, a);
    acks += int'(a);
    for (int i = 0; i < v.n; i++)
      if (v.addr[0]) begin
        rd_byte(i == v.n - 1, d);
        check("rd_data", d, rd_exp.size() != 0 ? int'(rd_exp.pop_front()) : -1);
      end else begin
        if (v.busy) wr_exp.push_back(8'(v.base + i));
        wr_byte(8'(v.base + i), a);
        acks += int'(a);
      end
    check("busy_before_stop", busy_o, v.busy);
    stop_c();
    wt(T);
    check("acks", acks, v.exp_acks);
    check("start_pulses", n_start - s_start, 1);
    check("stop_pulses", n_stop - s_stop, 1);
    check("wr_strobes", n_wr - s_wr, v.exp_wr);
    check("rd_requests", n_rdreq - s_req, v.exp_rdreq);
    check_range("scl_stretch_cycles", n_scl_low - s_scl, v.st_lo, v.st_hi);
    check("busy_seen", n_busy != s_busy, v.busy);
    check("busy_after_stop", busy_o, 0);
    check("op", op_o, v.op);
    if (!v.busy) check("sda_low_cycles", n_sda_low - s_sda, 0);
  endtask
  initial begin
    int s_start, s_stop, s_wr, s_req, acks;
    logic a, r;
    logic [7:0] d;
    vecs[0] = '{8'h44, 32, 0, 0, 33, 32, 0, 0, 0, 1'b1, 1'b0};
    vecs[1] = '{8'h45, 32, 100, 0, 1, 0, 32, 32, 32, 1'b1, 1'b1};
    vecs[2] = '{8'h46, 2, 7, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1};
    vecs[3] = '{8'h45, 1, 200, 50, 1, 0, 1, 50, 51, 1'b1, 1'b1};
    wt(3);
    check("rst_scl_o", scl_o, 1);
    check("rst_sda_o", sda_o, 1);
    check("rst_start_o", start_o, 0);
    check("rst_stop_o", stop_o, 0);
    check("rst_rd_req_o", rd_req_o, 0);
    check("rst_busy_o", busy_o, 0);
    check("rst_op_o", op_o, 0);
    check("rst_wr_data_o", wr_data_o, 0);
    check("rst_wr_valid_o", wr_valid_o, 0);
    rst = 0;
    wt(T);
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);
    s_start = n_start;
    s_stop = n_stop;
    s_wr = n_wr;
    s_req = n_rdreq;
    acks = 0;
    rd_delay = 0;
    for (int i = 0; i < 64; i++) begin
      rd_src.push_back(8'(63 - i));
      start_c();
      wr_byte(8'h44, a);
      acks += int'(a);
      wr_exp.push_back(8'(64 + i));
      wr_byte(8'(64 + i), a);
      acks += int'(a);
      start_c();
      wr_byte(8'h45, a);
      acks += int'(a);
      rd_byte(1'b1, d);
      check("rs_rd_data", d, rd_exp.size() != 0 ? int'(rd_exp.pop_front()) : -1);
    end
    stop_c();
    wt(T);
    check("rs_acks", acks, 192);
    check("rs_start_pulses", n_start - s_start, 128);
    check("rs_stop_pulses", n_stop - s_stop, 1);
    check("rs_wr_strobes", n_wr - s_wr, 64);
    check("rs_rd_requests", n_rdreq - s_req, 64);
    rd_src.push_back(8'h00);
    start_c();
    wr_byte(8'h45, a);
    check("rst_seq_addr_ack", a, 1);
    for (int i = 0; i < 3; i++) bit_x(1'b1, r);
    check("rst_seq_sda_driven", sda_o, 0);
    rst = 1;
    #1;
    check("async_rst_scl_o", scl_o, 1);
    check("async_rst_sda_o", sda_o, 1);
    check("async_rst_busy_o", busy_o, 0);
    wt(1);
    m_scl = 1;
    m_sda = 1;
    wt(T);
    rst = 0;
    wt(T);
    rd_src.delete();
    rd_exp.delete();
    run_vec('{8'h44, 1, 90, 0, 2, 1, 0, 0, 0, 1'b1, 1'b0});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable single-address I2C slave (responder). It is the target end of the I2C bus driven by the iicmb_m_wb controller.
- Oversamples scl/sda on the system clock, detects START, repeated START and STOP, and matches a 7-bit address.
- Write bytes from the master are presented on a strobe interface. Read bytes are fetched through a request/valid handshake; scl is stretched until read data is available.
- Lets the controller be exercised against RTL, not only against the behavioural bus model.

Parameters:
- I2C_ADDR_WIDTH, 7, slave address width.
- I2C_DATA_WIDTH, 8, byte width (fixed at 8 by the protocol; other values are unsupported).
- SLAVE_ADDRESS, 7'h22, address this slave ACKs.
- SYNC_STAGES, 2, flop stages on scl_i/sda_i before edge detection (minimum 2).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- scl_i  in  1  I2C clock, sampled from the bus
- sda_i  in  1  I2C data, sampled from the bus
- scl_o  out  1  open-drain clock drive: 0 pulls low, 1 releases
- sda_o  out  1  open-drain data drive: 0 pulls low, 1 releases
- start_o  out  1  one-cycle pulse on START or repeated START
- stop_o  out  1  one-cycle pulse on STOP
- op_o  out  1  R/W bit of the last matched address (1 = read)
- wr_data_o  out  8  received write byte
- wr_valid_o  out  1  one-cycle strobe, wr_data_o valid
- rd_req_o  out  1  level request for the next read byte
- rd_data_i  in  8  read byte
- rd_valid_i  in  1  rd_data_i valid; accepted in any cycle rd_req_o=1
- busy_o  out  1  high from a matched address until STOP

Behaviour:
- Reset (asynchronous, takes effect immediately even mid-byte):
  - scl_o=1, sda_o=1, all pulses 0, rd_req_o=0, busy_o=0, op_o=0, wr_data_o=0, state IDLE.
  - Synchronizers are preset to 1.
- Synchronized signals are scl_s and sda_s; their edges are detected one cycle after the sync chain.
- Bus condition detection:
  - START: sda_s falls while scl_s=1.
  - STOP: sda_s rises while scl_s=1.
- START/STOP have priority over any state:
  - START -> ADDR; bit counter cleared; sda_o released; start_o pulses.
  - STOP -> IDLE; sda_o and scl_o released; busy_o=0; stop_o pulses.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_WAIT, RD_BYTE, RD_ACK, SKIP.
- Bit sampling and driving:
  - Bits are sampled on the scl_s rising edge, MSB first.
  - sda_o changes only in the cycle after a detected scl_s falling edge.
- ADDR:
  - Shift 8 bits. After the 8th rising edge, compare bits[7:1] to SLAVE_ADDRESS.
  - Match: latch op_o=bit0, set busy_o, go to ADDR_ACK.
  - Mismatch: go to SKIP; sda_o is never driven.
- ADDR_ACK:
  - On the next scl falling edge, drive sda_o=0. Release it on the following falling edge.
  - op_o=0 -> WR_BYTE.
  - op_o=1 -> RD_WAIT, entered at that same falling edge.
- WR_BYTE: after 8 bits, wr_data_o is updated and wr_valid_o pulses in the cycle after the 8th rising edge. Go to WR_ACK.
- WR_ACK: always ACK (sda_o=0 for the 9th clock, as in ADDR_ACK), then back to WR_BYTE.
- RD_WAIT:
  - rd_req_o=1; scl_o=0 stretches the clock.
  - Exit in the cycle rd_valid_i=1: latch rd_data_i, rd_req_o=0, drive MSB on sda_o. scl_o releases one cycle later.
  - If rd_valid_i=1 in the first RD_WAIT cycle, the stretch lasts exactly one clock.
- RD_BYTE:
  - Shift out the next bit on each scl falling edge.
  - After the 8th bit's falling edge, release sda_o and go to RD_ACK.
- RD_ACK:
  - Sample the master's bit on the scl rising edge.
  - 0 (ACK) -> RD_WAIT at the next falling edge.
  - 1 (NACK) -> SKIP.
- SKIP: outputs released; wait for STOP or START.
- Drive hazard: the scl falling edge that precedes a STOP never causes sda_o=0 outside ACK/read-bit phases.
- Simultaneous rd_valid_i and STOP: STOP wins and the byte is discarded.
- rd_valid_i outside RD_WAIT is ignored.
- wr_valid_o and rd_req_o are never high in the same cycle.

Test Plan:
- START, address 0x44 (0x22 write), bytes 0..31, STOP:
  - 33 ACKs on the bus.
  - wr_valid_o pulses 32 times with wr_data_o 0..31 in order.
  - start_o and stop_o each pulse once; op_o=0.
- START, address 0x45, master ACKs 31 bytes then NACKs the 32nd; responder returns 100..131 with rd_valid_i immediately:
  - Master receives 100..131.
  - rd_req_o asserted exactly 32 times.
  - SKIP after NACK; busy_o drops at STOP.
- Address 0x46 (0x23 write) with 2 data bytes:
  - sda_o stays 1 throughout; no wr_valid_o; busy_o stays 0.
- Repeated-start loop, 64 iterations: write 64+i, repeated START, read with NACK, responder supplies 63-i:
  - start_o pulses twice per iteration.
  - Write data 64..127 and read data 63..0 are correct.
  - One stop_o at the end.
- Read with rd_valid_i delayed 50 clocks:
  - scl_o=0 for 50 or 51 clocks.
  - Byte value intact; no bit lost.
- rst_i asserted mid read byte while sda_o=0:
  - scl_o and sda_o are 1 within the same cycle (asynchronous).
  - After release, the next START and address 0x44 are handled normally.
